// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
//   flags_t  : packed {n, z, v, c} flag word as written to the flag register file
//   FLAG_*   : bit positions of each flag inside the 4-bit flag word
//   calc_v   : signed overflow from the carries into and out of the MSB
// Optional feature macro (used by the files that import this package): ADDSUB_SATURATE_EN
package addsub_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    function automatic logic calc_v(input logic cin_msb, input logic cout_msb);
        return cin_msb ^ cout_msb;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operation/result bundle between the EX-stage issue logic and pipelined_addsub.
//   in_valid, a, b, sub (, sat) : operation presented by the master
//   out_valid, result, flags    : registered result returned by the slave
// When ADDSUB_SATURATE_EN is defined an extra 'sat' request bit travels with the op.
interface pipelined_addsub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
`ifdef ADDSUB_SATURATE_EN
    logic             sat;
`endif
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

`ifdef ADDSUB_SATURATE_EN
    modport master (output in_valid, a, b, sub, sat, input out_valid, result, flags);
    modport slave  (input in_valid, a, b, sub, sat, output out_valid, result, flags);
`else
    modport master (output in_valid, a, b, sub, input out_valid, result, flags);
    modport slave  (input in_valid, a, b, sub, output out_valid, result, flags);
`endif

endinterface

// File: rtl/addsub_slice.sv
// Combinational SW-bit ripple-carry adder built from fullAdder cells.
//   a, b, cin : slice operands (b already inverted for subtraction) and carry in
//   sum       : slice sum
//   cout      : carry out of the slice MSB
//   cmsb      : carry into the slice MSB (overflow detection in the top slice)
module addsub_slice #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);
    logic [SW:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SW; i++) begin : g_bit
        fullAdder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[SW];
    assign cmsb = c[SW-1];
endmodule

// File: rtl/fullAdder.sv
// Single-bit gate-level full adder cell.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with {N, Z, V, C} flags.
// Operands are cut into STAGES slices of SW = WIDTH/STAGES bits; stage k adds slice k
// and registers its carry for stage k+1. Latency is STAGES cycles, one op per cycle.
//   clk, reset : clock, synchronous active-high reset (wins over stall)
//   stall      : freezes every pipeline register; in_valid is ignored meanwhile
//   bus        : pipelined_addsub_if slave (in_valid, a, b, sub, out_valid, result, flags)
// WIDTH must be a multiple of STAGES.
// ADDSUB_SATURATE_EN: adds bus.sat; on signed overflow the result clamps to the signed
// max/min (by A's sign) while the flags still report the raw sum.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    pipelined_addsub_if.slave bus
);
    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}});

    // Inputs seen by each stage: element 0 comes from the bus, element k from stage k-1.
    // st_a/st_b carry the whole operands skewed along; st_s holds the slices summed so far.
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];
`ifdef ADDSUB_SATURATE_EN
    logic             st_sat [STAGES];
`endif

    logic [SW-1:0]    sl_sum  [STAGES];
    logic             sl_cout [STAGES];
    logic             sl_cmsb [STAGES];
    logic [WIDTH-1:0] sum_full [STAGES];

    assign st_a[0] = bus.a;
    assign st_b[0] = bus.sub ? ~bus.b : bus.b;
    assign st_s[0] = '0;
    assign st_c[0] = bus.sub;   // the +1 of A + ~B + 1
    assign st_v[0] = bus.in_valid;
`ifdef ADDSUB_SATURATE_EN
    assign st_sat[0] = bus.sat;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_slice #(
            .SW (SW)
        ) u_slice (
            .a    (st_a[k][k*SW +: SW]),
            .b    (st_b[k][k*SW +: SW]),
            .cin  (st_c[k]),
            .sum  (sl_sum[k]),
            .cout (sl_cout[k]),
            .cmsb (sl_cmsb[k])
        );

        // Merge this slice's sum into the partial result gathered so far.
        assign sum_full[k] = (st_s[k] & ~(SLICE_MASK << (k * SW)))
                           | (WIDTH'(sl_sum[k]) << (k * SW));

        if (k < LAST) begin : g_reg
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
            logic             v_q;
`ifdef ADDSUB_SATURATE_EN
            logic             sat_q;
`endif

            // Datapath loads on bubbles too; only the valid bit marks the slot empty.
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
                    sat_q <= 1'b0;
`endif
                end else if (!stall) begin
                    a_q <= st_a[k];
                    b_q <= st_b[k];
                    s_q <= sum_full[k];
                    c_q <= sl_cout[k];
                    v_q <= st_v[k];
`ifdef ADDSUB_SATURATE_EN
                    sat_q <= st_sat[k];
`endif
                end
            end

            assign st_a[k+1] = a_q;
            assign st_b[k+1] = b_q;
            assign st_s[k+1] = s_q;
            assign st_c[k+1] = c_q;
            assign st_v[k+1] = v_q;
`ifdef ADDSUB_SATURATE_EN
            assign st_sat[k+1] = sat_q;
`endif
        end
    end

    // Final stage: flags from the complete raw sum, optional clamp, output registers.
    logic [WIDTH-1:0] res_d;
    flags_t           flags_d;

    always_comb begin
        flags_d.n = sum_full[LAST][WIDTH-1];
        flags_d.z = (sum_full[LAST] == '0);
        flags_d.v = calc_v(sl_cmsb[LAST], sl_cout[LAST]);
        flags_d.c = sl_cout[LAST];
        res_d     = sum_full[LAST];
`ifdef ADDSUB_SATURATE_EN
        if (st_sat[LAST] && flags_d.v) begin
            res_d = st_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    flags_t           flags_q;

    // result/flags only load with a valid op so they hold across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (!stall) begin
            out_valid_q <= st_v[LAST];
            if (st_v[LAST]) begin
                result_q <= res_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flg;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic stall;

    pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipelined_addsub #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   adv_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flag word helper: {N, Z, V, C}
    function automatic logic [3:0] fl(input logic n, input logic z, input logic v,
                                      input logic c);
        logic [3:0] f;
        f = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sub,
                         input logic sat, input logic [63:0] er, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
`ifdef ADDSUB_SATURATE_EN
        bus.sat      = sat;
`else
        if (sat) $display("note: sat request ignored in this build");
`endif
        e.res = er;
        e.flg = ef;
        e.cnt = adv_cnt;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.a        = 64'hDEAD_BEEF_0BAD_F00D;
            bus.b        = 64'h0123_4567_89AB_CDEF;
        end
    endtask

    // Monitor: pops one expectation per advancing cycle that shows out_valid.
    initial begin
        exp_t e;
        logic adv;
        forever begin
            @(posedge clk);
            adv = !stall && !reset;
            if (adv) adv_cnt++;
            #2;
            if (bus.out_valid && adv) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid: got result=%h expected no output",
                             bus.result);
                end else begin
                    e = sb.pop_front();
                    chk("result", bus.result, e.res);
                    chk("flags", {60'd0, bus.flags}, {60'd0, e.flg});
                    chk("latency", 64'(adv_cnt), 64'(e.cnt + STAGES));
                end
            end
        end
    end

    initial begin
        logic [63:0] snap_res;
        logic [3:0]  snap_flg;
        logic        snap_v;

        reset        = 1'b1;
        stall        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.sub      = 1'b0;
`ifdef ADDSUB_SATURATE_EN
        bus.sat      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_result", bus.result, 64'd0);
        chk("reset_flags", {60'd0, bus.flags}, 64'd0);

        issue(64'd5, 64'd7, 1'b0, 1'b0, 64'd12, fl(0, 0, 0, 0));
        idle(2);
        chk("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("idle_result_zero", bus.result, 64'd0);
        idle(4);
        // Held across bubbles: last valid result stays visible.
        chk("hold_result", bus.result, 64'd12);

        issue(64'd3, 64'd5, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, fl(1, 0, 0, 0));
        issue(64'h1234, 64'h1234, 1'b1, 1'b0, 64'd0, fl(0, 1, 0, 1));
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000,
              fl(1, 0, 1, 0));
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, fl(0, 1, 0, 1));
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF,
              fl(0, 0, 1, 1));
        issue(64'd0, 64'd0, 1'b1, 1'b0, 64'd0, fl(0, 1, 0, 1));
        issue(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
              64'h0001_0000_0001_0000, fl(0, 0, 0, 0));
`ifdef ADDSUB_SATURATE_EN
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,
              fl(1, 0, 1, 0));
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 64'h8000_0000_0000_0000,
              fl(0, 0, 1, 1));
        issue(64'd5, 64'd7, 1'b0, 1'b1, 64'd12, fl(0, 0, 0, 0));
`endif
        idle(6);

        // Back-to-back: results 0,3,6,9,12,15 on consecutive cycles.
        for (int i = 0; i < 6; i++) begin
            issue(64'(i), 64'(i * 2), 1'b0, 1'b0, 64'(i * 3), fl(0, i == 0, 0, 0));
        end
        idle(6);

        // Stall with a valid op sitting on the output and three more in flight.
        for (int i = 1; i <= 4; i++) begin
            issue(64'(100 * i), 64'(i), 1'b1, 1'b0, 64'(99 * i), fl(0, 0, 0, 1));
        end
        @(negedge clk);
        stall        = 1'b1;
        bus.in_valid = 1'b1;   // must be ignored while stalled
        bus.a        = 64'd1;
        bus.b        = 64'd1;
        bus.sub      = 1'b0;
        snap_v   = bus.out_valid;
        snap_res = bus.result;
        snap_flg = bus.flags;
        chk("stall_entry_valid", {63'd0, snap_v}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {63'd0, bus.out_valid}, {63'd0, snap_v});
            chk("stall_result", bus.result, snap_res);
            chk("stall_flags", {60'd0, bus.flags}, {60'd0, snap_flg});
        end
        stall        = 1'b0;
        bus.in_valid = 1'b0;
        idle(6);

        // Reset with two ops in flight: they must vanish.
        issue(64'd11, 64'd22, 1'b0, 1'b0, 64'd33, fl(0, 0, 0, 0));
        issue(64'd44, 64'd55, 1'b0, 1'b0, 64'd99, fl(0, 0, 0, 0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("post_reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
            chk("post_reset_result", bus.result, 64'd0);
            @(negedge clk);
        end

        // Final op after reset confirms the pipe restarts cleanly.
        issue(64'd1000, 64'd1, 1'b1, 1'b0, 64'd999, fl(0, 0, 0, 1));
        idle(8);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
